matmul_seq: RTL and testbench

- Sequential, parametrised N x N unsigned matrix multiply unit for the SIMD processor datapath.
- Takes two packed matrices A and B through a valid/ready input handshake and computes C = A x B one result row per clock.
- Presents C on a valid/ready output handshake.
- Adds two things to the fixed 4x4 combinational multiply: a selectable wrap/saturate mode and a sticky overflow flag.

---
 rtl/matmul_seq.sv | 158 +++++++++++++++
 tb/tb_matmul_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// matmul_seq: sequential N x N unsigned matrix multiply.
// Operands are latched on a valid/ready accept. One row of C is produced per
// clock, with per-element wrap or saturate reduction and a sticky overflow flag.
// The completed C is held on a valid/ready output until the consumer takes it.
module matmul_seq #(
    parameter int BITS_INDEX  = 8,
    parameter int MATRIX_SIZE = 4,
    parameter int WIDTH_V     = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode_sat,
    input  logic [WIDTH_V-1:0] a,
    input  logic [WIDTH_V-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_V-1:0] result,
    output logic               overflow,
    output logic               busy
);

    localparam int N     = MATRIX_SIZE;
    localparam int NN    = N * N;
    localparam int ACC_W = 2 * BITS_INDEX + $clog2(N);
    localparam int ROW_W = $clog2(N);
    localparam int IDX_W = $clog2(NN);
    localparam logic [ACC_W-1:0] MAX_ELEM = ACC_W'({BITS_INDEX{1'b1}});

    if (WIDTH_V != BITS_INDEX * MATRIX_SIZE * MATRIX_SIZE) begin : g_bad_width
        $error("matmul_seq: WIDTH_V must equal BITS_INDEX*MATRIX_SIZE*MATRIX_SIZE");
    end

    typedef logic [BITS_INDEX-1:0] elem_t;
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    // Flat element index of (row, col) in row-major order.
    function automatic logic [IDX_W-1:0] elem_idx(input int r, input int c);
        return IDX_W'(r * N + c);
    endfunction

    // Reduce a full-precision dot product to one element: wrap or clamp.
    function automatic elem_t reduce_sum(input logic [ACC_W-1:0] s, input logic sat);
        if (sat && (s > MAX_ELEM)) begin
            return '1;
        end
        return s[BITS_INDEX-1:0];
    endfunction

    elem_t            a_el [NN];
    elem_t            b_el [NN];
    elem_t            a_q  [NN];
    elem_t            b_q  [NN];
    elem_t            c_q  [NN];
    elem_t            row_res_d [N];
    logic             row_ovf_d;
    logic [ACC_W-1:0] acc_d;
    logic [ROW_W-1:0] row_q;
    logic             mode_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    state_t           state_q;

    // Element 0 sits in the MSBs of each packed vector.
    for (genvar i = 0; i < NN; i++) begin : g_pack
        assign a_el[i] = a[BITS_INDEX*(NN-i)-1 -: BITS_INDEX];
        assign b_el[i] = b[BITS_INDEX*(NN-i)-1 -: BITS_INDEX];
        assign result[BITS_INDEX*(NN-i)-1 -: BITS_INDEX] = c_q[i];
    end

    // Full-width dot products for the current row, reduced per element.
    always_comb begin
        row_ovf_d = 1'b0;
        acc_d     = '0;
        for (int j = 0; j < N; j++) begin
            acc_d = '0;
            for (int k = 0; k < N; k++) begin
                acc_d = acc_d + (ACC_W'(a_q[elem_idx(int'(row_q), k)]) *
                                 ACC_W'(b_q[elem_idx(k, j)]));
            end
            row_res_d[j] = reduce_sum(acc_d, mode_q);
            if (acc_d > MAX_ELEM) begin
                row_ovf_d = 1'b1;
            end
        end
    end

    // Control FSM with registered handshake outputs and operand/result storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NN; i++) begin
                            a_q[i] <= a_el[i];
                            b_q[i] <= b_el[i];
                        end
                        mode_q     <= mode_sat;
                        ovf_q      <= 1'b0;
                        row_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    for (int j = 0; j < N; j++) begin
                        c_q[elem_idx(int'(row_q), j)] <= row_res_d[j];
                    end
                    ovf_q <= ovf_q | row_ovf_d;
                    if (row_q == ROW_W'(N - 1)) begin
                        row_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: default 4x4x8 instance plus a 2x2x16 instance.
module tb_matmul_seq;

    localparam logic [127:0] ID4   = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] SEQ   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] ALL10 = {16{8'h10}};
    localparam logic [127:0] ALL03 = {16{8'h03}};
    localparam logic [127:0] ALL24 = {16{8'h24}};
    localparam logic [127:0] ALLFF = {16{8'hFF}};

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, mode_sat, out_valid, out_ready, overflow, busy;
    logic [127:0] a, b, result;
    logic         in_valid2, in_ready2, mode_sat2, out_valid2, out_ready2, overflow2, busy2;
    logic [63:0]  a2, b2, result2;

    int n_cmp = 0;
    int n_bad = 0;

    matmul_seq #(.BITS_INDEX(8), .MATRIX_SIZE(4), .WIDTH_V(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode_sat(mode_sat), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow), .busy(busy)
    );

    matmul_seq #(.BITS_INDEX(16), .MATRIX_SIZE(2), .WIDTH_V(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .mode_sat(mode_sat2), .a(a2), .b(b2), .out_valid(out_valid2),
        .out_ready(out_ready2), .result(result2), .overflow(overflow2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: element idx at bits*(n*n-1-idx) from bit 0.
    function automatic void ref_mm(input logic [127:0] av, input logic [127:0] bv,
                                   input int n, input int bits, input bit sat,
                                   output logic [127:0] cv, output bit ovf);
        logic [127:0] mask;
        longint unsigned s, ea, eb, maxv;
        mask = (128'd1 << bits) - 128'd1;
        maxv = (64'd1 << bits) - 64'd1;
        cv   = '0;
        ovf  = 1'b0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    ea = 64'((av >> (bits * (n*n - 1 - (r*n + k)))) & mask);
                    eb = 64'((bv >> (bits * (n*n - 1 - (k*n + c)))) & mask);
                    s  = s + ea * eb;
                end
                if (s > maxv) begin
                    ovf = 1'b1;
                    if (sat) s = maxv;
                end
                cv = cv | (128'(s & maxv) << (bits * (n*n - 1 - (r*n + c))));
            end
        end
    endfunction

    // Present operands for one accept edge, then scramble them.
    task automatic start_op(input logic [127:0] av, input logic [127:0] bv, input bit sat);
        a = av; b = bv; mode_sat = sat; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~av; b = ~bv; mode_sat = ~sat;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 32) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_op(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_release_ovalid: got %b want 0", name, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_release_iready: got %b want 1", name, in_ready); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (result !== 128'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++; if (result2 !== 64'd0) begin n_bad++; $display("FAIL reset_result2: got %h want 0", result2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity;
        int lat;
        start_op(ID4, SEQ, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ident_busy: got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ident_in_ready: got %b want 0", in_ready); end
        wait_valid(lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ident_latency: got %0d want 4", lat); end
        n_cmp++; if (result !== SEQ) begin n_bad++; $display("FAIL ident_result: got %h want %h", result, SEQ); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ident_overflow: got %b want 0", overflow); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ident_ready_overlap: got %b want 0", in_ready); end
        release_op("ident");
    endtask

    task automatic test_wrap_sat;
        int lat;
        start_op(ALL10, ALL10, 1'b0);
        wait_valid(lat);
        n_cmp++; if (result !== 128'd0) begin n_bad++; $display("FAIL wrap_result: got %h want 0", result); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL wrap_overflow: got %b want 1", overflow); end
        release_op("wrap");
        start_op(ALL10, ALL10, 1'b1);
        wait_valid(lat);
        n_cmp++; if (result !== ALLFF) begin n_bad++; $display("FAIL sat_result: got %h want %h", result, ALLFF); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat_overflow: got %b want 1", overflow); end
        release_op("sat");
        start_op(ALL03, ALL03, 1'b1);
        wait_valid(lat);
        n_cmp++; if (result !== ALL24) begin n_bad++; $display("FAIL sat3_result: got %h want %h", result, ALL24); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat3_overflow: got %b want 0", overflow); end
        release_op("sat3");
    endtask

    task automatic test_backpressure;
        int lat;
        start_op(ALL10, ALL10, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            b = ID4;
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (result !== 128'd0) begin n_bad++; $display("FAIL bp_result[%0d]: got %h want 0", i, result); end
            n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow[%0d]: got %b want 1", i, overflow); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        release_op("bp");
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_no_queue: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_op;
        int  lat;
        logic seen;
        start_op(ALL10, ALL10, 1'b1);
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rmid_row0_ovf: got %b want 1", overflow); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 128'd0) begin n_bad++; $display("FAIL rmid_result: got %h want 0", result); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_stray_valid: got %b want 0", seen); end
        start_op(ID4, ID4, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rmid_latency: got %0d want 4", lat); end
        n_cmp++; if (result !== ID4) begin n_bad++; $display("FAIL rmid_ident: got %h want %h", result, ID4); end
        release_op("rmid");
    endtask

    task automatic test_back_to_back;
        logic [127:0] opa [3];
        logic [127:0] opb [3];
        logic [127:0] expc [3];
        bit           ops  [3];
        int           acc_cyc [3];
        int           cyc, acc_n, done_n;
        bit           accepting;
        opa[0] = ID4;   opb[0] = SEQ;   ops[0] = 1'b0; expc[0] = SEQ;
        opa[1] = ALL03; opb[1] = ALL03; ops[1] = 1'b1; expc[1] = ALL24;
        opa[2] = SEQ;   opb[2] = ID4;   ops[2] = 1'b0; expc[2] = SEQ;
        cyc = 0; acc_n = 0; done_n = 0;
        a = opa[0]; b = opb[0]; mode_sat = ops[0];
        in_valid = 1'b1; out_ready = 1'b1;
        while (done_n < 3 && cyc < 60) begin
            accepting = in_ready && in_valid;
            n_cmp++; if (in_ready && out_valid) begin n_bad++; $display("FAIL b2b_overlap[%0d]: got in_ready=1 out_valid=1 want exclusive", cyc); end
            if (out_valid) begin
                n_cmp++; if (result !== expc[done_n]) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", done_n, result, expc[done_n]); end
                done_n++;
            end
            tick();
            cyc++;
            if (accepting) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) begin
                    a = opa[acc_n]; b = opb[acc_n]; mode_sat = ops[acc_n];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        n_cmp++; if (done_n !== 3) begin n_bad++; $display("FAIL b2b_done: got %0d want 3", done_n); end
        n_cmp++; if (acc_n !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 3", acc_n); end
        if (acc_n == 3) begin
            n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin n_bad++; $display("FAIL b2b_period01: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
            n_cmp++; if (acc_cyc[2] - acc_cyc[1] !== 6) begin n_bad++; $display("FAIL b2b_period12: got %0d want 6", acc_cyc[2] - acc_cyc[1]); end
        end
        tick();
    endtask

    task automatic op2(input logic [63:0] av, input logic [63:0] bv, input bit sat,
                       input logic [63:0] expc, input bit expo, input string name);
        int lat;
        a2 = av; b2 = bv; mode_sat2 = sat; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0; a2 = ~av; b2 = ~bv;
        lat = 0;
        while (!out_valid2 && lat < 32) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
        n_cmp++; if (result2 !== expc) begin n_bad++; $display("FAIL %s_result: got %h want %h a=%h b=%h m=%0d", name, result2, expc, av, bv, sat); end
        n_cmp++; if (overflow2 !== expo) begin n_bad++; $display("FAIL %s_overflow: got %b want %b", name, overflow2, expo); end
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    task automatic test_param_sweep;
        logic [63:0]  av, bv;
        logic [127:0] cv;
        bit           ov;
        op2(64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008, 1'b0,
            64'h0013_0016_002B_0032, 1'b0, "n2_direct");
        op2({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0, {4{16'h0002}}, 1'b1, "n2_wrap");
        op2({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b1, {4{16'hFFFF}}, 1'b1, "n2_sat");
        for (int i = 0; i < 200; i++) begin
            av = {$urandom(), $urandom()};
            bv = {$urandom(), $urandom()};
            if (i[1]) begin
                av = av & 64'h00FF_00FF_00FF_00FF;
                bv = bv & 64'h00FF_00FF_00FF_00FF;
            end
            ref_mm({64'd0, av}, {64'd0, bv}, 2, 16, i[0], cv, ov);
            op2(av, bv, i[0], cv[63:0], ov, "n2_rand");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; mode_sat = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; mode_sat2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b0;
        test_reset();
        test_identity();
        test_wrap_sat();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
